// File: rtl/pwm_duty_meter_pkg.sv
// Shared constants and helpers for the PWM duty meter: default window timing,
// FSM state encodings and the per-channel count width.
package pwm_duty_meter_pkg;

   localparam int DEF_CLOCKS_PER_SAMPLE = 2500;
   localparam int CLOCK_FREQ            = 125_000_000;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // Width that holds 0..clocks_per_sample inclusive, so an all-high window cannot wrap.
   function automatic int cnt_width(input int clocks_per_sample);
      return $clog2(clocks_per_sample + 1);
   endfunction

endpackage

// File: rtl/pwm_meter_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is visible whenever valid_o is high.
module pwm_meter_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic             full_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             empty_s, wr_en_s, rd_en_s;

   assign empty_s = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign valid_o = !empty_s;
   assign data_o  = empty_s ? {WIDTH{1'b0}} : mem_q[rd_q[AW-1:0]];

   // A pop in the same cycle frees the slot, so a push at full is still accepted.
   assign rd_en_s = pop_i && !empty_s;
   assign wr_en_s = push_i && (!full_o || rd_en_s);

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (wr_en_s) begin
         wr_d = wr_q + {{AW{1'b0}}, 1'b1};
      end else begin
         wr_d = wr_q;
      end
      if (rd_en_s) begin
         rd_d = rd_q + {{AW{1'b0}}, 1'b1};
      end else begin
         rd_d = rd_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         if (wr_en_s) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
         end
      end
   end

endmodule

// File: rtl/pwm_duty_meter.sv
// Multi-channel PWM duty meter: counts synchronized high cycles per channel over
// fixed windows and queues one packed count vector per window into a FWFT FIFO.
module pwm_duty_meter
   import pwm_duty_meter_pkg::*;
#(
   parameter int  CLOCKS_PER_SAMPLE = DEF_CLOCKS_PER_SAMPLE,
   parameter int  N_CH              = 2,
   parameter int  FIFO_DEPTH        = 8,
   parameter int  SYNC_STAGES       = 2,
   localparam int CW                = cnt_width(CLOCKS_PER_SAMPLE)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [N_CH-1:0]      pwm_in,
   output logic [N_CH*CW-1:0]   out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 window_tick,
   output logic [15:0]          drop_count
);

   localparam int              PW         = $clog2(CLOCKS_PER_SAMPLE);
   localparam logic [PW-1:0]   LAST_PHASE = PW'(CLOCKS_PER_SAMPLE - 1);

   logic [N_CH-1:0]    sync_q [SYNC_STAGES];
   logic [N_CH-1:0]    pwm_s;
   logic [0:0]         state_q, state_d;
   logic [PW-1:0]      phase_q, phase_d, phase_s;
   logic [CW-1:0]      cnt_q [N_CH];
   logic [CW-1:0]      cnt_d [N_CH];
   logic [CW-1:0]      sum_s [N_CH];
   logic [N_CH*CW-1:0] push_data_s;
   logic               last_s, pop_s, full_s;
   logic [15:0]        drop_q, drop_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= pwm_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign pwm_s = sync_q[SYNC_STAGES-1];

   // The enabling edge out of IDLE closes phase 0, so IDLE reads as phase 0.
   assign phase_s     = (state_q == ST_RUN) ? phase_q : {PW{1'b0}};
   assign last_s      = enable && (phase_s == LAST_PHASE);
   assign window_tick = last_s;
   assign pop_s       = out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      if (enable) begin
         state_d = ST_RUN;
         phase_d = last_s ? {PW{1'b0}} : phase_s + PW'(1);
      end else begin
         state_d = ST_IDLE;
         phase_d = {PW{1'b0}};
      end
   end

   always_comb begin
      push_data_s = '0;
      for (int k = 0; k < N_CH; k++) begin
         sum_s[k] = cnt_q[k] + CW'(pwm_s[k]);
         if (!enable || last_s) begin
            cnt_d[k] = {CW{1'b0}};
         end else begin
            cnt_d[k] = sum_s[k];
         end
         push_data_s[k*CW +: CW] = sum_s[k];
      end
   end

   always_comb begin
      drop_d = drop_q;
      if (last_s && full_s && !pop_s && (drop_q != 16'hFFFF)) begin
         drop_d = drop_q + 16'd1;
      end else begin
         drop_d = drop_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         phase_q <= '0;
         drop_q  <= 16'd0;
         for (int k = 0; k < N_CH; k++) begin
            cnt_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         drop_q  <= drop_d;
         for (int k = 0; k < N_CH; k++) begin
            cnt_q[k] <= cnt_d[k];
         end
      end
   end

   assign drop_count = drop_q;

   pwm_meter_fifo #(
      .WIDTH (N_CH*CW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (last_s),
      .data_i  (push_data_s),
      .pop_i   (out_ready),
      .data_o  (out_data),
      .valid_o (out_valid),
      .full_o  (full_s)
   );

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Bench for pwm_duty_meter: window/queue model checked every cycle, plus directed scenarios.
module tb_pwm_duty_meter;

   localparam int CPS   = 5;
   localparam int NCH   = 2;
   localparam int DEPTH = 4;
   localparam int CWB   = 3;

   logic              clk;
   logic              rst_n;
   logic              enable;
   logic [NCH-1:0]    pwm_in;
   logic [NCH*CWB-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              window_tick;
   logic [15:0]       drop_count;

   int n_cmp  = 0;
   int n_fail = 0;
   int n_ticks = 0;
   int pcyc   = 0;
   bit pat_on = 0;
   int lat;
   logic [5:0] got [$];

   // model state
   logic [1:0] m_pipe [2];
   int         m_sum [2];
   int         m_wcnt;
   logic [5:0] m_q [$];
   int         m_drop;

   pwm_duty_meter #(
      .CLOCKS_PER_SAMPLE (CPS),
      .N_CH              (NCH),
      .FIFO_DEPTH        (DEPTH),
      .SYNC_STAGES       (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .pwm_in      (pwm_in),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .window_tick (window_tick),
      .drop_count  (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (pat_on) begin
         pwm_in = {((pcyc % 5) < 3) ? 1'b1 : 1'b0, pcyc[0]};
         pcyc++;
      end
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   // Returns at the falling edge inside a tick cycle.
   task automatic wait_tick();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (window_tick) seen = 1'b1;
         else step();
      end
      chk("wait_tick_seen", seen, 1);
   endtask

   // Behavioural model: windows of CPS enabled cycles, sums of input delayed two clocks.
   initial begin
      logic [1:0] s;
      logic [5:0] e;
      bit push, pop;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_pipe[0] = 2'b00; m_pipe[1] = 2'b00;
            m_sum[0] = 0; m_sum[1] = 0; m_wcnt = 0;
            m_q.delete(); m_drop = 0;
         end else begin
            s = m_pipe[1];
            m_pipe[1] = m_pipe[0];
            m_pipe[0] = pwm_in;
            push = 1'b0;
            e = 6'd0;
            if (!enable) begin
               m_sum[0] = 0; m_sum[1] = 0; m_wcnt = 0;
            end else begin
               m_sum[0] += int'(s[0]);
               m_sum[1] += int'(s[1]);
               m_wcnt++;
               if (m_wcnt == CPS) begin
                  push = 1'b1;
                  e = {3'(m_sum[1]), 3'(m_sum[0])};
                  m_sum[0] = 0; m_sum[1] = 0; m_wcnt = 0;
               end
            end
            pop = (m_q.size() > 0) && out_ready;
            if (push && (m_q.size() == DEPTH) && !pop) begin
               if (m_drop < 65535) m_drop++;
            end else if (push) begin
               if (pop) void'(m_q.pop_front());
               m_q.push_back(e);
               pop = 1'b0;
            end
            if (pop) void'(m_q.pop_front());
         end
      end
   end

   // Compare DUT outputs against the model mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            chk("out_valid", out_valid, (m_q.size() > 0) ? 32'd1 : 32'd0);
            chk("out_data", out_data, (m_q.size() > 0) ? m_q[0] : 6'd0);
            chk("window_tick", window_tick, (enable && (m_wcnt == CPS - 1)) ? 32'd1 : 32'd0);
            chk("drop_count", drop_count, m_drop);
            if (out_valid && out_ready) got.push_back(out_data);
            if (window_tick) n_ticks++;
         end
      end
   end

   initial begin
      rst_n = 1'b0; enable = 1'b0; pwm_in = 2'b00; out_ready = 1'b1;
      run(3);
      chk("reset_valid", out_valid, 0);
      chk("reset_data", out_data, 0);
      chk("reset_tick", window_tick, 0);
      chk("reset_drop", drop_count, 0);
      rst_n = 1'b1;

      // 1: latency of the first entry, then an async reset mid-window
      step();
      enable = 1'b1; pwm_in = 2'b11; out_ready = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
      chk("first_entry_latency", lat, 5);
      chk("first_entry_data", out_data, 6'o33);
      run(7);
      #3 rst_n = 1'b0;
      #1;
      chk("async_reset_valid", out_valid, 0);
      chk("async_reset_data", out_data, 0);
      chk("async_reset_drop", drop_count, 0);
      enable = 1'b0; pwm_in = 2'b00; out_ready = 1'b1;
      step();
      rst_n = 1'b1;

      // 2: constant levels
      pwm_in = 2'b01;
      run(4);
      got.delete(); n_ticks = 0;
      enable = 1'b1;
      run(25);
      chk("levels_ticks", n_ticks, 5);
      chk("levels_entries", got.size(), 4);
      foreach (got[i]) chk("levels_value", got[i], 6'o05);

      // 3: duty patterns
      enable = 1'b0; pat_on = 1'b1;
      run(4);
      got.delete();
      enable = 1'b1;
      run(32);
      chk("duty_entries", (got.size() >= 4) ? 1 : 0, 1);
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         chk("duty_ch1", got[i][5:3], 3);
         if (i > 0) chk("duty_ch0_alt", got[i][2:0] + got[i-1][2:0], 5);
      end

      // 4: backpressure for seven windows
      wait_tick();
      step();
      out_ready = 1'b0;
      run(30);
      chk("bp_drop", drop_count, 3);
      chk("bp_valid", out_valid, 1);

      // 5: full FIFO, pop on a tick cycle
      wait_tick();
      #1 out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("fullpop_drop", drop_count, 3);
      chk("fullpop_valid", out_valid, 1);
      got.delete();
      out_ready = 1'b1;
      run(30);
      if (got.size() >= 4) begin
         chk("drain_order_01", got[0][2:0] + got[1][2:0], 5);
         chk("drain_order_12", got[1][2:0] + got[2][2:0], 5);
         chk("drain_order_23", got[3][2:0], got[2][2:0]);
      end else begin
         chk("drain_entries", got.size(), 4);
      end

      // 6: abort at phase 3, then re-enable
      pat_on = 1'b0; pwm_in = 2'b11;
      run(4);
      wait_tick();
      run(4);
      enable = 1'b0;
      n_ticks = 0;
      run(10);
      chk("abort_ticks", n_ticks, 0);
      chk("abort_valid", out_valid, 0);
      chk("abort_drop", drop_count, 3);
      pwm_in = 2'b01;
      run(3);
      got.delete();
      enable = 1'b1;
      run(7);
      chk("reenable_entries", got.size(), 1);
      if (got.size() > 0) chk("reenable_value", got[0], 6'o05);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
